// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES/3DES round-key generator.
// Applies PC1 to the selected key, then streams 16 PC2 subkeys per pass over a
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
// NUM_KEYS = 3 sequences the three EDE passes automatically.
// Optional macro DES_KEY_PARITY_CHECK_EN: refuses start when any key byte has
// even parity and reports it on parity_err.
module des_key_schedule #(
  parameter int unsigned NUM_KEYS    = 1,
  // Leftmost bit is round 1; a set bit means that round rotates by 2.
  parameter logic [15:0] SHIFT_SCHED = 16'b0011_1111_0111_1110
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    decrypt,
  input  logic [0:64*NUM_KEYS-1]  key_in,
  output logic [0:47]             subkey,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic [3:0]              round_idx,
  output logic [1:0]              key_sel,
  output logic                    last,
  output logic                    busy,
`ifdef DES_KEY_PARITY_CHECK_EN
  output logic                    parity_err,
`endif
  output logic                    done
);

  localparam int unsigned KEY_W     = 64 * NUM_KEYS;
  localparam int unsigned NUM_BYTES = 8 * NUM_KEYS;
  localparam logic [1:0]  LAST_PASS = 2'(NUM_KEYS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_GEN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (NUM_KEYS != 1 && NUM_KEYS != 3) begin : g_bad_num_keys
    $error("des_key_schedule: NUM_KEYS must be 1 or 3");
  end

  // Permuted choice 1: 64-bit key to 56-bit C||D, parity bits dropped.
  function automatic logic [0:55] pc1(input logic [0:63] k);
    pc1 = {k[56], k[48], k[40], k[32], k[24], k[16], k[8],
           k[0],  k[57], k[49], k[41], k[33], k[25], k[17],
           k[9],  k[1],  k[58], k[50], k[42], k[34], k[26],
           k[18], k[10], k[2],  k[59], k[51], k[43], k[35],
           k[62], k[54], k[46], k[38], k[30], k[22], k[14],
           k[6],  k[61], k[53], k[45], k[37], k[29], k[21],
           k[13], k[5],  k[60], k[52], k[44], k[36], k[28],
           k[20], k[12], k[4],  k[27], k[19], k[11], k[3]};
  endfunction

  // Permuted choice 2: 56-bit C||D to 48-bit round subkey.
  function automatic logic [0:47] pc2(input logic [0:55] cd);
    pc2 = {cd[13], cd[16], cd[10], cd[23], cd[0],  cd[4],
           cd[2],  cd[27], cd[14], cd[5],  cd[20], cd[9],
           cd[22], cd[18], cd[11], cd[3],  cd[25], cd[7],
           cd[15], cd[6],  cd[26], cd[19], cd[12], cd[1],
           cd[40], cd[51], cd[30], cd[36], cd[46], cd[54],
           cd[29], cd[39], cd[50], cd[44], cd[32], cd[47],
           cd[43], cd[48], cd[38], cd[55], cd[33], cd[52],
           cd[45], cd[41], cd[49], cd[35], cd[28], cd[31]};
  endfunction

  // 28-bit rotations in DES bit order (bit 0 is leftmost).
  function automatic logic [0:27] rot_l(input logic [0:27] x, input logic two);
    rot_l = two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
  endfunction

  function automatic logic [0:27] rot_r(input logic [0:27] x, input logic two);
    rot_r = two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
  endfunction

  // Rotation amount for 0-based round r: 1 = rotate by 2.
  function automatic logic shift_two(input logic [3:0] r);
    shift_two = SHIFT_SCHED[4'(4'd15 - r)];
  endfunction

  // Middle pass of EDE runs in the opposite direction.
  function automatic logic pass_mode(input logic [1:0] pass, input logic dec);
    pass_mode = (NUM_KEYS == 3) ? (dec ^ (pass == 2'd1)) : dec;
  endfunction

  function automatic logic [1:0] key_index(input logic [1:0] pass, input logic dec);
    key_index = dec ? 2'(LAST_PASS - pass) : pass;
  endfunction

  logic [1:0]       r_state, w_state_nxt;
  logic [0:27]      r_c, r_d, w_c_nxt, w_d_nxt;
  logic [0:KEY_W-1] r_key, w_key_nxt;
  logic             r_decrypt, w_dec_nxt;
  logic [1:0]       r_pass, w_pass_nxt;
  logic [3:0]       r_round, w_round_nxt;
  logic             r_valid, r_busy, r_done, r_last, w_last_nxt;
  logic [1:0]       w_ksel;
  logic             w_mode;
  logic             w_pass_end;
  logic [0:63]      w_sel_key;
  logic [0:55]      w_pc1;
  logic             w_accept;
  logic             w_two;

`ifdef DES_KEY_PARITY_CHECK_EN
  logic r_parity_err, w_perr_nxt, w_par_ok;

  // Every key byte must carry odd parity.
  always_comb begin
    w_par_ok = 1'b1;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (!(^key_in[8*b +: 8])) w_par_ok = 1'b0;
    end
  end
`endif

  assign w_ksel     = key_index(r_pass, r_decrypt);
  assign w_mode     = pass_mode(r_pass, r_decrypt);
  assign w_pass_end = w_mode ? (r_round == 4'd0) : (r_round == 4'd15);
  assign w_pc1      = pc1(w_sel_key);

  // Key selected for the pass being loaded.
  if (NUM_KEYS == 3) begin : g_key_mux3
    always_comb begin
      case (w_ksel)
        2'd1:    w_sel_key = r_key[64:127];
        2'd2:    w_sel_key = r_key[128:191];
        default: w_sel_key = r_key[0:63];
      endcase
    end
  end else begin : g_key_mux1
    assign w_sel_key = r_key[0:63];
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_key_nxt   = r_key;
    w_dec_nxt   = r_decrypt;
    w_pass_nxt  = r_pass;
    w_round_nxt = r_round;
    w_two       = 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
    w_perr_nxt  = r_parity_err;
    w_accept    = start & w_par_ok;
`else
    w_accept    = start;
`endif
    if (abort) begin
      w_state_nxt = S_IDLE;
`ifdef DES_KEY_PARITY_CHECK_EN
      w_perr_nxt  = 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef DES_KEY_PARITY_CHECK_EN
          if (start) w_perr_nxt = ~w_par_ok;
`endif
          if (w_accept) begin
            w_key_nxt   = key_in;
            w_dec_nxt   = decrypt;
            w_pass_nxt  = 2'd0;
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          // C16D16 equals C0D0, so decrypt starts from the unrotated halves.
          if (w_mode) begin
            w_c_nxt     = w_pc1[0:27];
            w_d_nxt     = w_pc1[28:55];
            w_round_nxt = 4'd15;
          end else begin
            w_c_nxt     = rot_l(w_pc1[0:27], 1'b0);
            w_d_nxt     = rot_l(w_pc1[28:55], 1'b0);
            w_round_nxt = 4'd0;
          end
          w_state_nxt = S_GEN;
        end
        S_GEN: begin
          if (subkey_ready) begin
            if (w_pass_end) begin
              if (r_pass != LAST_PASS) begin
                w_pass_nxt  = r_pass + 2'd1;
                w_state_nxt = S_LOAD;
              end else begin
                w_state_nxt = S_DONE;
              end
            end else if (w_mode) begin
              w_two       = shift_two(r_round);
              w_c_nxt     = rot_r(r_c, w_two);
              w_d_nxt     = rot_r(r_d, w_two);
              w_round_nxt = r_round - 4'd1;
            end else begin
              w_two       = shift_two(r_round + 4'd1);
              w_c_nxt     = rot_l(r_c, w_two);
              w_d_nxt     = rot_l(r_d, w_two);
              w_round_nxt = r_round + 4'd1;
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign w_last_nxt = (w_state_nxt == S_GEN) && (w_pass_nxt == LAST_PASS) &&
                      (w_round_nxt == (pass_mode(w_pass_nxt, w_dec_nxt) ? 4'd0 : 4'd15));

  // State, key/CD registers and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= S_IDLE;
      r_c          <= '0;
      r_d          <= '0;
      r_key        <= '0;
      r_decrypt    <= 1'b0;
      r_pass       <= 2'd0;
      r_round      <= 4'd0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_last       <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_c          <= w_c_nxt;
      r_d          <= w_d_nxt;
      r_key        <= w_key_nxt;
      r_decrypt    <= w_dec_nxt;
      r_pass       <= w_pass_nxt;
      r_round      <= w_round_nxt;
      r_valid      <= (w_state_nxt == S_GEN);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
      r_last       <= w_last_nxt;
`ifdef DES_KEY_PARITY_CHECK_EN
      r_parity_err <= w_perr_nxt;
`endif
    end
  end

  assign subkey       = pc2({r_c, r_d});
  assign subkey_valid = r_valid;
  assign round_idx    = r_round;
  assign key_sel      = w_ksel;
  assign last         = r_last;
  assign busy         = r_busy;
  assign done         = r_done;
`ifdef DES_KEY_PARITY_CHECK_EN
  assign parity_err   = r_parity_err;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed bench for des_key_schedule (1-key and 3-key builds).
module tb_des_key_schedule;

  localparam int LIMIT = 400;
  localparam logic [0:63] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [0:63] KEY_Z = 64'h0101010101010101; // effective key all zeros
  localparam logic [0:63] KEY_O = 64'hFEFEFEFEFEFEFEFE; // effective key all ones

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        s1, a1, d1, r1, v1, l1, b1, dn1;
  logic [0:63] k1;
  logic [0:47] sk1;
  logic [3:0]  ri1;
  logic [1:0]  ks1;
  logic        s3, a3, d3, r3, v3, l3, b3, dn3;
  logic [0:191] k3;
  logic [0:47] sk3;
  logic [3:0]  ri3;
  logic [1:0]  ks3;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        perr1, perr3;
`endif

  des_key_schedule #(.NUM_KEYS(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(s1), .abort(a1), .decrypt(d1), .key_in(k1),
    .subkey(sk1), .subkey_valid(v1), .subkey_ready(r1), .round_idx(ri1),
    .key_sel(ks1), .last(l1), .busy(b1),
`ifdef DES_KEY_PARITY_CHECK_EN
    .parity_err(perr1),
`endif
    .done(dn1));

  des_key_schedule #(.NUM_KEYS(3)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .start(s3), .abort(a3), .decrypt(d3), .key_in(k3),
    .subkey(sk3), .subkey_valid(v3), .subkey_ready(r3), .round_idx(ri3),
    .key_sel(ks3), .last(l3), .busy(b3),
`ifdef DES_KEY_PARITY_CHECK_EN
    .parity_err(perr3),
`endif
    .done(dn3));

  // Hand-derived subkeys K1..K16 for KEY_A.
  logic [47:0] enc_tab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  int n_checks = 0;
  int n_errors = 0;

  logic [47:0] cap_k [64];
  logic [3:0]  cap_r [64];
  logic [1:0]  cap_s [64];
  logic        cap_l [64];
  int n_hs, done_cyc, n_done, n_bubble, first_v, stall_viol;

  logic [47:0] exp_k [64];
  logic [3:0]  exp_r [64];
  logic [1:0]  exp_s [64];
  logic        exp_l [64];
  int n_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Append one pass of 16 expected subkeys; kind 0 = KEY_A table, 1 = zeros, 2 = ones.
  task automatic add_pass(input logic [1:0] sel, input bit dec, input int kind);
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = dec ? 15 - i : i;
      exp_r[n_exp] = 4'(idx);
      exp_s[n_exp] = sel;
      exp_k[n_exp] = (kind == 0) ? enc_tab[idx] : (kind == 1) ? 48'h0 : 48'hFFFFFFFFFFFF;
      exp_l[n_exp] = 1'b0;
      n_exp++;
    end
  endtask

  // Issue start on one DUT and record every handshake until just after done.
  task automatic run_op(input int which, input bit dec, input logic [0:191] keys, input bit rnd);
    logic o_v, o_busy, o_done, o_l, rdy, prev_v, prev_rdy;
    logic [47:0] o_k, prev_k;
    logic [3:0]  o_r, prev_r;
    logic [1:0]  o_s;
    n_hs = 0; done_cyc = -1; n_done = 0; n_bubble = 0; first_v = -1; stall_viol = 0;
    prev_v = 1'b0; prev_rdy = 1'b1; prev_k = '0; prev_r = '0;
    if (which == 1) begin k1 = keys[0:63]; d1 = dec; r1 = 1'b1; s1 = 1'b1; end
    else            begin k3 = keys;       d3 = dec; r3 = 1'b1; s3 = 1'b1; end
    @(negedge clk);
    s1 = 1'b0; s3 = 1'b0;
    for (int cyc = 1; cyc <= LIMIT; cyc++) begin
      if (which == 1) begin o_v = v1; o_k = sk1; o_r = ri1; o_s = ks1; o_l = l1; o_busy = b1; o_done = dn1; end
      else            begin o_v = v3; o_k = sk3; o_r = ri3; o_s = ks3; o_l = l3; o_busy = b3; o_done = dn3; end
      if (prev_v && !prev_rdy && !(o_v && o_k == prev_k && o_r == prev_r)) stall_viol++;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (which == 1) r1 = rdy; else r3 = rdy;
      if (o_v && first_v < 0) first_v = cyc;
      if (o_v && rdy && n_hs < 64) begin
        cap_k[n_hs] = o_k; cap_r[n_hs] = o_r; cap_s[n_hs] = o_s; cap_l[n_hs] = o_l;
        n_hs++;
      end
      if (o_busy && !o_v && !o_done) n_bubble++;
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_v = o_v; prev_rdy = rdy; prev_k = o_k; prev_r = o_r;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    r1 = 1'b1; r3 = 1'b1;
  endtask

  // Compare the captured run against the expected table and timing.
  task automatic check_run(input string name, input int nk, input bit timing);
    chk({name, " handshakes"}, 64'(n_hs), 64'(n_exp));
    for (int i = 0; i < n_exp && i < n_hs; i++) begin
      chk($sformatf("%s subkey[%0d]", name, i), 64'(cap_k[i]), 64'(exp_k[i]));
      chk($sformatf("%s round[%0d]", name, i),  64'(cap_r[i]), 64'(exp_r[i]));
      chk($sformatf("%s keysel[%0d]", name, i), 64'(cap_s[i]), 64'(exp_s[i]));
      chk($sformatf("%s last[%0d]", name, i),   64'(cap_l[i]), 64'(exp_l[i]));
    end
    chk({name, " done pulses"}, 64'(n_done), 64'd1);
    chk({name, " first valid cycle"}, 64'(first_v), 64'd2);
    if (timing) begin
      // done appears 17*nk+1 edges after start is sampled (17*nk+2 cycles inclusive)
      chk({name, " done cycle"}, 64'(done_cyc), 64'(17 * nk + 1));
      chk({name, " load bubbles"}, 64'(n_bubble), 64'(nk));
    end
  endtask

  initial begin
    int found, dn_seen;
    n_rst = 1'b0;
    s1 = 0; a1 = 0; d1 = 0; r1 = 1; k1 = '0;
    s3 = 0; a3 = 0; d3 = 0; r3 = 1; k3 = '0;
    @(negedge clk); @(negedge clk);

    // Reset state
    chk("rst valid",  64'(v1),  64'd0);
    chk("rst busy",   64'(b1),  64'd0);
    chk("rst done",   64'(dn1), 64'd0);
    chk("rst last",   64'(l1),  64'd0);
    chk("rst round",  64'(ri1), 64'd0);
    chk("rst keysel", 64'(ks1), 64'd0);
    chk("rst subkey", 64'(sk1), 64'd0);
    chk("rst3 valid", 64'(v3),  64'd0);
    chk("rst3 subkey", 64'(sk3), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Single DES encrypt
    n_exp = 0; add_pass(2'd0, 1'b0, 0); exp_l[n_exp-1] = 1'b1;
    run_op(1, 1'b0, {KEY_A, 128'h0}, 1'b0);
    check_run("enc1", 1, 1'b1);

    // Single DES decrypt: reverse order
    n_exp = 0; add_pass(2'd0, 1'b1, 0); exp_l[n_exp-1] = 1'b1;
    run_op(1, 1'b1, {KEY_A, 128'h0}, 1'b0);
    check_run("dec1", 1, 1'b1);

    // Random backpressure, encrypt
    n_exp = 0; add_pass(2'd0, 1'b0, 0); exp_l[n_exp-1] = 1'b1;
    run_op(1, 1'b0, {KEY_A, 128'h0}, 1'b1);
    check_run("stall1", 1, 1'b0);
    chk("stall1 stability", 64'(stall_viol), 64'd0);

    // 3DES encrypt: E(A) D(Z) E(O)
    n_exp = 0;
    add_pass(2'd0, 1'b0, 0); add_pass(2'd1, 1'b1, 1); add_pass(2'd2, 1'b0, 2);
    exp_l[n_exp-1] = 1'b1;
    run_op(3, 1'b0, {KEY_A, KEY_Z, KEY_O}, 1'b0);
    check_run("enc3", 3, 1'b1);

    // 3DES decrypt: D(O) E(Z) D(A)
    n_exp = 0;
    add_pass(2'd2, 1'b1, 2); add_pass(2'd1, 1'b0, 1); add_pass(2'd0, 1'b1, 0);
    exp_l[n_exp-1] = 1'b1;
    run_op(3, 1'b1, {KEY_A, KEY_Z, KEY_O}, 1'b0);
    check_run("dec3", 3, 1'b1);

    // Abort at round 7
    k1 = KEY_A; d1 = 1'b0; r1 = 1'b1; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    found = 0;
    for (int c = 0; c < 30; c++) begin
      if (v1 && ri1 == 4'd7) begin found = 1; break; end
      @(negedge clk);
    end
    chk("abort reached round 7", 64'(found), 64'd1);
    a1 = 1'b1;
    @(negedge clk);
    a1 = 1'b0;
    chk("abort valid", 64'(v1), 64'd0);
    chk("abort busy",  64'(b1), 64'd0);
    dn_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (dn1) dn_seen++;
      @(negedge clk);
    end
    chk("abort no done", 64'(dn_seen), 64'd0);

    // Reset mid-GEN
    s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset valid", 64'(v1), 64'd1);
    n_rst = 1'b0;
    #1;
    chk("mid reset valid",  64'(v1),  64'd0);
    chk("mid reset busy",   64'(b1),  64'd0);
    chk("mid reset round",  64'(ri1), 64'd0);
    chk("mid reset subkey", 64'(sk1), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    dn_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (dn1 || b1) dn_seen++;
      @(negedge clk);
    end
    chk("after reset idle", 64'(dn_seen), 64'd0);

    // Clean run after abort and reset
    n_exp = 0; add_pass(2'd0, 1'b0, 0); exp_l[n_exp-1] = 1'b1;
    run_op(1, 1'b0, {KEY_A, 128'h0}, 1'b0);
    check_run("rerun1", 1, 1'b1);

`ifdef DES_KEY_PARITY_CHECK_EN
    // All-zero key bytes have even parity: start refused
    k1 = 64'h0; s1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    chk("parity err set", 64'(perr1), 64'd1);
    chk("parity busy",    64'(b1),    64'd0);
    @(negedge clk);
    chk("parity still idle", 64'(b1), 64'd0);
    n_exp = 0; add_pass(2'd0, 1'b0, 0); exp_l[n_exp-1] = 1'b1;
    run_op(1, 1'b0, {KEY_A, 128'h0}, 1'b0);
    check_run("parity ok run", 1, 1'b1);
    chk("parity err cleared", 64'(perr1), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
